// File: rtl/jtag_cmd_ctrl_if.sv
// Purpose: bundles the JTAG byte channel, memory req/gnt port and NPU start
// handshake of jtag_cmd_ctrl into one interface.
//   master : the command controller (drives tx_*, mem_req/we/addr/wdata,
//            npu_start, busy, err)
//   slave  : the surrounding JTAG bridge, memory and NPU
interface jtag_cmd_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 16
);
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          npu_start;
    logic          npu_busy;
    logic          busy;
    logic          err;

    modport master (
        input  rx_valid, rx_data, tx_ack, mem_gnt, mem_rvalid, mem_rdata, npu_busy,
        output tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata,
               npu_start, busy, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ack, mem_gnt, mem_rvalid, mem_rdata, npu_busy,
        input  tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata,
               npu_start, busy, err
    );
endinterface

// File: rtl/jtag_cmd_ctrl.sv
// Purpose: parses host byte streams from the virtual-JTAG channel into
// WRITE / READ / START commands, runs the memory transactions over a req/gnt
// port and returns read data through a small FIFO to the JTAG capture path.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : jtag_cmd_ctrl_if.master (rx byte strobe, tx FIFO head/ack,
//              memory req/gnt/rvalid, npu_start/npu_busy, busy, err)
module jtag_cmd_ctrl #(
    parameter int unsigned DW         = 8,
    parameter int unsigned AW         = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    jtag_cmd_ctrl_if.master bus
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LW = DW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_ADDR0 = 3'd2;
    localparam logic [2:0] S_ADDR1 = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_WMEM  = 3'd5;
    localparam logic [2:0] S_RREQ  = 3'd6;
    localparam logic [2:0] S_RWAIT = 3'd7;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_START = 2'b11;

    logic [2:0]    state_q,     state_d;
    logic          is_write_q,  is_write_d;
    logic [LW-1:0] rem_q,       rem_d;
    logic [DW-1:0] addr_lo_q,   addr_lo_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic          npu_start_q, npu_start_d;
    logic          busy_q,      busy_d;
    logic          err_q,       err_d;

    logic [DW-1:0] fifo_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [DW-1:0] tx_data_q,   tx_data_d;
    logic          tx_valid_q,  tx_valid_d;

    logic          push;
    logic          pop;
    logic          gnt;

    assign gnt = mem_req_q && bus.mem_gnt;

    // Read-return FIFO; registered head so tx_data is valid the cycle after a push/pop.
    always_comb begin
        push     = (state_q == S_RWAIT) && bus.mem_rvalid;
        pop      = bus.tx_ack && (count_q != '0);
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = bus.mem_rdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d    = count_q + CW'(push) - CW'(pop);
        tx_valid_d = (count_d != '0);
        // fifo_d already holds a same-cycle push, which covers the empty-FIFO bypass
        tx_data_d  = (count_d != '0) ? fifo_d[rd_ptr_d] : '0;
    end

    // Command parser / memory sequencer
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        rem_d       = rem_q;
        addr_lo_d   = addr_lo_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        npu_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data[7:6])
                        OP_NOP: begin
                            if (bus.rx_data[0]) err_d = 1'b0;
                        end
                        OP_WRITE, OP_READ: begin
                            if (bus.rx_data[5:0] != 6'd0) begin
                                err_d = 1'b1;
                            end else begin
                                is_write_d = (bus.rx_data[7:6] == OP_WRITE);
                                state_d    = S_LEN;
                            end
                        end
                        OP_START: begin
                            if (bus.rx_data[5:0] != 6'd0 || bus.npu_busy) err_d = 1'b1;
                            else                                          npu_start_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    rem_d   = LW'(bus.rx_data) + LW'(1);
                    state_d = S_ADDR0;
                end
            end
            S_ADDR0: begin
                if (bus.rx_valid) begin
                    addr_lo_d = bus.rx_data;
                    state_d   = S_ADDR1;
                end
            end
            S_ADDR1: begin
                if (bus.rx_valid) begin
                    addr_d  = AW'({bus.rx_data, addr_lo_q});
                    state_d = is_write_q ? S_WDATA : S_RREQ;
                end
            end
            S_WDATA: begin
                if (bus.rx_valid) begin
                    wdata_d = bus.rx_data;
                    state_d = S_WMEM;
                end
            end
            S_WMEM: begin
                if (bus.rx_valid) err_d = 1'b1;
                if (gnt) begin
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - LW'(1);
                    state_d = (rem_q == LW'(1)) ? S_IDLE : S_WDATA;
                end
            end
            S_RREQ: begin
                if (bus.rx_valid) err_d = 1'b1;
                if (gnt) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (bus.rx_valid) err_d = 1'b1;
                if (bus.mem_rvalid) begin
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - LW'(1);
                    state_d = (rem_q == LW'(1)) ? S_IDLE : S_RREQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // In RREQ nothing is outstanding, so a free FIFO slot is the only condition.
        mem_req_d = (state_d == S_WMEM) ||
                    ((state_d == S_RREQ) && (count_d < CW'(FIFO_DEPTH)));
        mem_we_d  = (state_d == S_WMEM);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            rem_q       <= '0;
            addr_lo_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            npu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            rem_q       <= rem_d;
            addr_lo_q   <= addr_lo_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            npu_start_q <= npu_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.npu_start = npu_start_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_jtag_cmd_ctrl.sv
// Purpose: self-checking bench for jtag_cmd_ctrl with a memory model,
// write/read scoreboards and directed command scenarios.
module tb_jtag_cmd_ctrl;

    logic clk;
    logic rst;

    jtag_cmd_ctrl_if #(.DW(8), .AW(16)) bus ();

    jtag_cmd_ctrl #(.DW(8), .AW(16), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // memory model state
    logic        gnt_en     = 1'b1;
    int          rv_lat     = 1;
    int          pend_cnt   = 0;
    logic [7:0]  pend_data  = 8'h00;
    int          rd_gnt_cnt = 0;
    logic [23:0] obs_wr [0:63];
    int          obs_n      = 0;
    int          obs_idx    = 0;

    // scoreboards
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // preloaded memory contents for reads
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign bus.mem_gnt = bus.mem_req & gnt_en;

    // memory model: records writes, returns read data rv_lat cycles after grant
    always @(posedge clk) begin
        bus.mem_rvalid <= 1'b0;
        if (pend_cnt == 1) begin
            bus.mem_rvalid <= 1'b1;
            bus.mem_rdata  <= pend_data;
        end
        if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) begin
                if (obs_n < 64) obs_wr[obs_n] <= {bus.mem_addr, bus.mem_wdata};
                obs_n <= obs_n + 1;
            end else begin
                rd_gnt_cnt <= rd_gnt_cnt + 1;
                if (rv_lat <= 1) begin
                    bus.mem_rvalid <= 1'b1;
                    bus.mem_rdata  <= pat(bus.mem_addr);
                end else begin
                    pend_cnt  <= rv_lat - 1;
                    pend_data <= pat(bus.mem_addr);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0)    begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0)  begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h0)  begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
        checks++; if (bus.tx_data !== 8'h0)    begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
        checks++; if (bus.tx_valid !== 1'b0)   begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        checks++; if (bus.npu_start !== 1'b0)  begin failures++; $display("FAIL reset_npu_start got=%b exp=0", bus.npu_start); end
        checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        exp_wr.push_back({16'h0010, 8'hAA});
        exp_wr.push_back({16'h0011, 8'hBB});
        send(8'h40); send(8'h01); send(8'h10); send(8'h00); send(8'hAA);
        send(8'hBB);
        // one cycle after the last data byte: request presented
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL write_req got req=%b we=%b exp 1 1", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0011 || bus.mem_wdata !== 8'hBB) begin failures++; $display("FAIL write_bus got addr=%h data=%h exp 0011 bb", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL write_busy_hi got=%b exp=1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL write_busy_fall got busy=%b req=%b exp 0 0", bus.busy, bus.mem_req); end
        repeat (2) @(negedge clk);
        while (exp_wr.size() > 0) begin
            logic [23:0] e;
            e = exp_wr.pop_front();
            checks++;
            if (obs_idx >= obs_n) begin failures++; $display("FAIL write_sb missing got=none exp=%h", e); end
            else if (obs_wr[obs_idx] !== e) begin failures++; $display("FAIL write_sb got=%h exp=%h", obs_wr[obs_idx], e); end
            obs_idx++;
        end
        checks++; if (obs_n != obs_idx) begin failures++; $display("FAIL write_sb_extra got=%0d exp=%0d", obs_n, obs_idx); end
    endtask

    task automatic test_read_backpressure();
        int g0;
        g0 = rd_gnt_cnt;
        for (int i = 0; i < 8; i++) exp_rd.push_back(pat(16'(i)));
        send(8'h80); send(8'h07); send(8'h00); send(8'h00);
        repeat (20) @(negedge clk);
        checks++; if (rd_gnt_cnt - g0 != 4) begin failures++; $display("FAIL read_stall_reqs got=%0d exp=4", rd_gnt_cnt - g0); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL read_stall_busy got=%b exp=1", bus.busy); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            int         exp_g;
            e = exp_rd.pop_front();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== e) begin
                failures++; $display("FAIL read_data[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, e);
            end
            bus.tx_ack = 1'b1;
            @(negedge clk);
            bus.tx_ack = 1'b0;
            repeat (6) @(negedge clk);
            exp_g = (i + 5 > 8) ? 8 : i + 5;
            checks++; if (rd_gnt_cnt - g0 != exp_g) begin failures++; $display("FAIL read_release[%0d] got=%0d exp=%0d", i, rd_gnt_cnt - g0, exp_g); end
        end
        checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL read_drained got v=%b d=%h exp 0 00", bus.tx_valid, bus.tx_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL read_done_busy got=%b exp=0", bus.busy); end
        // ack on an empty FIFO is ignored
        bus.tx_ack = 1'b1;
        @(negedge clk);
        bus.tx_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL empty_ack got v=%b exp=0", bus.tx_valid); end
    endtask

    task automatic test_addr_wrap();
        exp_wr.push_back({16'hFFFF, 8'h11});
        exp_wr.push_back({16'h0000, 8'h22});
        send(8'h40); send(8'h01); send(8'hFF); send(8'hFF); send(8'h11); send(8'h22);
        repeat (3) @(negedge clk);
        while (exp_wr.size() > 0) begin
            logic [23:0] e;
            e = exp_wr.pop_front();
            checks++;
            if (obs_idx >= obs_n) begin failures++; $display("FAIL wrap_sb missing got=none exp=%h", e); end
            else if (obs_wr[obs_idx] !== e) begin failures++; $display("FAIL wrap_sb got=%h exp=%h", obs_wr[obs_idx], e); end
            obs_idx++;
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_errors();
        bus.npu_busy = 1'b1;
        send(8'hC0);
        checks++; if (bus.npu_start !== 1'b0 || bus.err !== 1'b1) begin failures++; $display("FAIL start_busy got start=%b err=%b exp 0 1", bus.npu_start, bus.err); end
        send(8'h41);
        @(negedge clk);
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL reserved got err=%b busy=%b exp 1 0", bus.err, bus.busy); end
        send(8'h01);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL nop_clear1 got=%b exp=0", bus.err); end
        // stall the grant and poke an extra byte during WMEM
        gnt_en = 1'b0;
        exp_wr.push_back({16'h0020, 8'h5A});
        send(8'h40); send(8'h00); send(8'h20); send(8'h00); send(8'h5A);
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL wmem_stall got req=%b err=%b exp 1 0", bus.mem_req, bus.err); end
        send(8'h77);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL wmem_extra_err got=%b exp=1", bus.err); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 8'h5A) begin
            failures++; $display("FAIL wmem_hold got req=%b addr=%h data=%h exp 1 0020 5a", bus.mem_req, bus.mem_addr, bus.mem_wdata);
        end
        gnt_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wmem_done got busy=%b exp=0", bus.busy); end
        while (exp_wr.size() > 0) begin
            logic [23:0] e;
            e = exp_wr.pop_front();
            checks++;
            if (obs_idx >= obs_n) begin failures++; $display("FAIL err_sb missing got=none exp=%h", e); end
            else if (obs_wr[obs_idx] !== e) begin failures++; $display("FAIL err_sb got=%h exp=%h", obs_wr[obs_idx], e); end
            obs_idx++;
        end
        checks++; if (obs_n != obs_idx) begin failures++; $display("FAIL err_sb_extra got=%0d exp=%0d", obs_n, obs_idx); end
        send(8'h01);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL nop_clear2 got=%b exp=0", bus.err); end
        bus.npu_busy = 1'b0;
        send(8'hC0);
        checks++; if (bus.npu_start !== 1'b1) begin failures++; $display("FAIL start_pulse got=%b exp=1", bus.npu_start); end
        @(negedge clk);
        checks++; if (bus.npu_start !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL start_one_cycle got start=%b err=%b exp 0 0", bus.npu_start, bus.err); end
    endtask

    task automatic test_mid_read_reset();
        int g;
        // leave two entries in the FIFO
        rv_lat = 1;
        send(8'h80); send(8'h01); send(8'h00); send(8'h01);
        repeat (12) @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== pat(16'h0100)) begin
            failures++; $display("FAIL pre_reset_fifo got v=%b d=%h exp v=1 d=%h", bus.tx_valid, bus.tx_data, pat(16'h0100));
        end
        // slow read, reset while waiting for rvalid
        rv_lat = 4;
        g = rd_gnt_cnt;
        send(8'h80); send(8'h00); send(8'h00); send(8'h02);
        for (int k = 0; k < 20 && rd_gnt_cnt == g; k++) @(negedge clk);
        checks++;
        if (rd_gnt_cnt == g) begin
            failures++; $display("FAIL mid_reset_grant_timeout got=%0d exp=%0d", rd_gnt_cnt, g + 1);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_req got req=%b busy=%b exp 0 0", bus.mem_req, bus.busy); end
        checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL mid_reset_fifo got v=%b d=%h exp 0 00", bus.tx_valid, bus.tx_data); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL late_rvalid got v=%b exp=0", bus.tx_valid); end
        checks++; if (rd_gnt_cnt != g + 1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL post_reset_idle got grants=%0d req=%b exp %0d 0", rd_gnt_cnt, bus.mem_req, g + 1); end
        rv_lat = 1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ack   = 1'b0;
        bus.npu_busy = 1'b0;
        test_reset();
        test_write();
        test_read_backpressure();
        test_addr_wrap();
        test_errors();
        test_mid_read_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_cmd_ctrl.md
# jtag_cmd_ctrl

Command sequencer between the virtual-JTAG byte channel and the NPU's on-chip memory and start logic. It parses host byte streams, arriving one byte per JTAG WRITE update, into write, read and start commands. It performs the memory transactions over a req/gnt port and queues read results in a 4-entry FIFO that feeds the JTAG READ capture path. It runs entirely in the system clock domain; JTAG-side strobes arrive already synchronized.

## Interface
- DW, 8, byte width of JTAG data and memory data
- AW, 16, memory address width; always two address bytes, upper bits beyond AW ignored
- FIFO_DEPTH, 4, read-return FIFO entries (power of two)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: new host byte on rx_data
- rx_data  in  DW  host byte (JTAG data_out, synchronized)
- tx_data  out  DW  FIFO head, to JTAG data_in; 0 when empty
- tx_valid  out  1  FIFO non-empty
- tx_ack  in  1  one-cycle strobe: host captured tx_data, pop
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  1=write, 0=read
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, exactly one per granted read, ≥1 cycle after gnt, in order
- mem_rdata  in  DW  read data
- npu_start  out  1  one-cycle NPU start pulse
- npu_busy  in  1  NPU running
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

## Operation
- Header byte: [7:6] opcode, [5:0] must be 0 except NOP. 00 NOP (bit0=1 clears err), 01 WRITE, 10 READ, 11 START.
- WRITE/READ header followed by LEN byte (N = LEN+1, 1..256), ADDR_LO, ADDR_HI; WRITE then N data bytes.
- States: IDLE, LEN, ADDR0, ADDR1, WDATA, WMEM, RREQ, RWAIT.
- IDLE: on rx_valid, decode. WRITE/READ -> LEN. START: if !npu_busy, pulse npu_start next cycle, else set err; stay IDLE. NOP: handle bit0, stay IDLE. Reserved bits nonzero: set err, stay IDLE.
- LEN -> ADDR0 -> ADDR1, each advancing on rx_valid. Leaving ADDR1: WRITE -> WDATA, READ -> RREQ.
- WDATA: on rx_valid, latch mem_wdata -> WMEM.
- WMEM: mem_req=1, mem_we=1. On mem_gnt, addr+1 mod 2^AW and remaining-1. If remaining reaches 0 -> IDLE, else -> WDATA.
- RREQ: mem_req=1, mem_we=0 only while FIFO count + outstanding < FIFO_DEPTH. On gnt -> RWAIT.
- RWAIT: on mem_rvalid, push mem_rdata, addr+1, remaining-1. If remaining reaches 0 -> IDLE, else -> RREQ.
- rx_valid in WMEM, RREQ or RWAIT: byte dropped, err set.
- tx_ack while FIFO empty is ignored. Push and pop in the same cycle leave count unchanged. A push to a full FIFO cannot occur (slot reserved before req).
- mem_addr, mem_we and mem_wdata hold stable while mem_req && !mem_gnt.
- err clears only by reset or NOP 0x01.

## Timing
- All outputs registered. Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_data=0, tx_valid=0, npu_start=0, busy=0, err=0. FIFO empty, state IDLE.
- Reset mid-command: abort immediately. No mem_req the next cycle. Bytes already written stay in memory; in-flight mem_rvalid after reset is ignored.
- Last WRITE data byte rx_valid at cycle t: mem_req=1 at t+1. If gnt at t+1, busy=0 at t+2.
- mem_rvalid at cycle t: tx_valid=1 and tx_data valid at t+1.
- tx_ack at t: next entry (or 0, tx_valid=0) at t+1.
- START byte at t: npu_start=1 at t+1 only.
- Throughput: one memory access per 2 cycles minimum (WDATA/RREQ + WMEM/RWAIT).

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, busy=0, err=0.
- Write: bytes 0x40,0x01,0x10,0x00,0xAA,0xBB with gnt immediate -> writes 0xAA@0x0010, 0xBB@0x0011. busy falls 1 cycle after second gnt.
- Read with backpressure: memory preloaded, READ LEN=7 @0x0000, no tx_ack -> exactly 4 reqs, then stall. Each tx_ack releases one req; all 8 bytes pop in address order.
- Address wrap: WRITE LEN=1 @0xFFFF -> writes @0xFFFF then @0x0000.
- Errors: 0xC0 with npu_busy=1 -> no npu_start, err=1. 0x41 -> err stays, IDLE. Extra rx_valid during WMEM -> err. 0x01 -> err=0. 0xC0 with npu_busy=0 -> one-cycle npu_start.
- Mid-read reset: rst during RWAIT -> mem_req=0 next cycle, FIFO empty, late mem_rvalid pushes nothing.
